register_bank: RTL and testbench

//   Parametrised bank of NREGS general-purpose registers of WIDTH bits; next generation of the

---
 rtl/register_bank_pkg.sv | 16 +
 rtl/reg_op_unit.sv | 42 ++++
 rtl/register_bank.sv | 102 ++++++++++
 tb/tb_register_bank.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank: write-mode encodings, also used by the control
// unit decoder.
package register_bank_pkg;

    typedef logic [2:0] wmode_t;

    localparam wmode_t MODE_HOLD = 3'b000;
    localparam wmode_t MODE_LOAD = 3'b001;
    localparam wmode_t MODE_CLR  = 3'b010;
    localparam wmode_t MODE_INC  = 3'b011;
    localparam wmode_t MODE_DEC  = 3'b100;
    localparam wmode_t MODE_SHL  = 3'b101;
    localparam wmode_t MODE_SHR  = 3'b110;
    localparam wmode_t MODE_RSVD = 3'b111;

endpackage

// File: rtl/reg_op_unit.sv
// Combinational write-port operator: computes the next register value and flags for one mode.
module reg_op_unit
    import register_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  wmode_t           wmode_i,
    output logic [WIDTH-1:0] next_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             changes_flags_o
);

    always_comb begin
        next_o          = r_i;
        carry_o         = 1'b0;
        changes_flags_o = 1'b1;
        unique case (wmode_i)
            MODE_LOAD: next_o = wdata_i;
            MODE_CLR:  next_o = '0;
            MODE_INC:  {carry_o, next_o} = {1'b0, r_i} + {{WIDTH{1'b0}}, 1'b1};
            MODE_DEC: begin
                next_o  = r_i - {{(WIDTH-1){1'b0}}, 1'b1};
                carry_o = (r_i == '0);
            end
            MODE_SHL: begin
                next_o  = {r_i[WIDTH-2:0], wdata_i[0]};
                carry_o = r_i[WIDTH-1];
            end
            MODE_SHR: begin
                next_o  = {wdata_i[0], r_i[WIDTH-1:1]};
                carry_o = r_i[0];
            end
            default: changes_flags_o = 1'b0;  // HOLD and reserved
        endcase
    end

    assign zero_o = (next_o == '0);

endmodule

// File: rtl/register_bank.sv
// Bank of NREGS registers with one moded write port, two combinational read ports and
// registered zero/carry flags for the control unit.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      NREGS     = 4,
    parameter int unsigned      SELW      = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               BYPASS    = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [SELW-1:0]  wsel_i,
    input  wmode_t           wmode_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [SELW-1:0]  rsel_a_i,
    input  logic [SELW-1:0]  rsel_b_i,
    output logic [WIDTH-1:0] out_a_o,
    output logic [WIDTH-1:0] out_b_o,
    output logic             zero_o,
    output logic             carry_o
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] wr_cur;
    logic             wsel_valid;
    logic [WIDTH-1:0] op_next;
    logic             op_carry, op_zero, op_flags;
    logic             wr_en;

    always_comb begin
        wr_cur     = '0;
        wsel_valid = 1'b0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (wsel_i == SELW'(i)) begin
                wr_cur     = regs_q[i];
                wsel_valid = 1'b1;
            end
        end
    end

    reg_op_unit #(
        .WIDTH (WIDTH)
    ) u_op (
        .r_i             (wr_cur),
        .wdata_i         (wdata_i),
        .wmode_i         (wmode_i),
        .next_o          (op_next),
        .carry_o         (op_carry),
        .zero_o          (op_zero),
        .changes_flags_o (op_flags)
    );

    assign wr_en = we_i & wsel_valid & op_flags;

    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && wsel_i == SELW'(i)) begin
                regs_d[i] = op_next;
            end
        end
        zero_d  = wr_en ? op_zero : zero_q;
        carry_d = wr_en ? op_carry : carry_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= RESET_VAL;
            end
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    // Out-of-range selects read as zero; bypass forwards the in-flight write result.
    always_comb begin
        out_a_o = '0;
        out_b_o = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (rsel_a_i == SELW'(i)) out_a_o = regs_q[i];
            if (rsel_b_i == SELW'(i)) out_b_o = regs_q[i];
        end
        if (BYPASS && wr_en && rsel_a_i == wsel_i) out_a_o = op_next;
        if (BYPASS && wr_en && rsel_b_i == wsel_i) out_b_o = op_next;
    end

    assign zero_o  = zero_q;
    assign carry_o = carry_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench: bank without bypass, with bypass, and a 3-register bank.
module tb_register_bank;
    import register_bank_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       we_i = 1'b0;
    logic [1:0] wsel_i = '0;
    wmode_t     wmode_i = MODE_HOLD;
    logic [7:0] wdata_i = '0;
    logic [1:0] rsel_a_i = '0;
    logic [1:0] rsel_b_i = '0;

    logic [7:0] a0, b0, a1, b1, a2, b2;
    logic       z0, c0, z1, c1, z2, c2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    register_bank #(.WIDTH(8), .NREGS(4), .SELW(2), .RESET_VAL(8'h00), .BYPASS(1'b0)) u_dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we_i), .wsel_i(wsel_i), .wmode_i(wmode_i),
        .wdata_i(wdata_i), .rsel_a_i(rsel_a_i), .rsel_b_i(rsel_b_i),
        .out_a_o(a0), .out_b_o(b0), .zero_o(z0), .carry_o(c0)
    );

    register_bank #(.WIDTH(8), .NREGS(4), .SELW(2), .RESET_VAL(8'h00), .BYPASS(1'b1)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we_i), .wsel_i(wsel_i), .wmode_i(wmode_i),
        .wdata_i(wdata_i), .rsel_a_i(rsel_a_i), .rsel_b_i(rsel_b_i),
        .out_a_o(a1), .out_b_o(b1), .zero_o(z1), .carry_o(c1)
    );

    register_bank #(.WIDTH(8), .NREGS(3), .SELW(2), .RESET_VAL(8'h00), .BYPASS(1'b0)) u_dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .we_i(we_i), .wsel_i(wsel_i), .wmode_i(wmode_i),
        .wdata_i(wdata_i), .rsel_a_i(rsel_a_i), .rsel_b_i(rsel_b_i),
        .out_a_o(a2), .out_b_o(b2), .zero_o(z2), .carry_o(c2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [1:0] sel, input wmode_t mode, input logic [7:0] data);
        @(negedge clk_i);
        we_i    = 1'b1;
        wsel_i  = sel;
        wmode_i = mode;
        wdata_i = data;
        @(posedge clk_i);
        #1;
        we_i    = 1'b0;
        wmode_i = MODE_HOLD;
    endtask

    task automatic read_a(input logic [1:0] sel);
        rsel_a_i = sel;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Async reset mid-cycle clears a loaded register immediately
        do_write(2'd0, MODE_LOAD, 8'h55);
        read_a(2'd0);
        check_eq("pre_reset_load", a0, 8'h55);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check_eq("reset_async_reg0", a0, 8'h00);
        check_eq("reset_zero", z0, 1'b0);
        check_eq("reset_carry", c0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // LOAD 0xA5 into reg 2
        do_write(2'd2, MODE_LOAD, 8'hA5);
        read_a(2'd2);
        check_eq("load_reg2", a0, 8'hA5);
        read_a(2'd0);
        check_eq("load_reg0_untouched", a0, 8'h00);
        read_a(2'd1);
        check_eq("load_reg1_untouched", a0, 8'h00);
        read_a(2'd3);
        check_eq("load_reg3_untouched", a0, 8'h00);
        check_eq("load_zero", z0, 1'b0);
        rsel_b_i = 2'd2;
        #1;
        check_eq("portb_reg2", b0, 8'hA5);

        // INC wrap and DEC borrow on reg 1
        do_write(2'd1, MODE_LOAD, 8'hFF);
        do_write(2'd1, MODE_INC, 8'h00);
        read_a(2'd1);
        check_eq("inc_wrap_val", a0, 8'h00);
        check_eq("inc_wrap_carry", c0, 1'b1);
        check_eq("inc_wrap_zero", z0, 1'b1);
        do_write(2'd1, MODE_DEC, 8'h00);
        read_a(2'd1);
        check_eq("dec_wrap_val", a0, 8'hFF);
        check_eq("dec_borrow_carry", c0, 1'b1);
        check_eq("dec_wrap_zero", z0, 1'b0);
        rsel_b_i = 2'd1;
        #1;
        check_eq("dut2_reg1", b2, 8'hFF);

        // Shifts on reg 3; the 3-register bank ignores wsel=3
        do_write(2'd3, MODE_LOAD, 8'h81);
        read_a(2'd3);
        check_eq("load81", a0, 8'h81);
        check_eq("load_clears_carry", c0, 1'b0);
        check_eq("dut2_wsel_oob_carry_hold", c2, 1'b1);
        check_eq("dut2_rsel_oob_zero", a2, 8'h00);
        do_write(2'd3, MODE_SHL, 8'h01);
        read_a(2'd3);
        check_eq("shl_val", a0, 8'h03);
        check_eq("shl_carry", c0, 1'b1);
        do_write(2'd3, MODE_SHR, 8'h00);
        read_a(2'd3);
        check_eq("shr_val", a0, 8'h01);
        check_eq("shr_carry", c0, 1'b1);
        do_write(2'd3, MODE_SHR, 8'h01);
        read_a(2'd3);
        check_eq("shr_in_val", a0, 8'h80);
        check_eq("shr_in_carry", c0, 1'b1);
        do_write(2'd3, MODE_SHL, 8'h00);
        read_a(2'd3);
        check_eq("shl_out_val", a0, 8'h00);
        check_eq("shl_out_zero", z0, 1'b1);
        do_write(2'd3, MODE_LOAD, 8'h40);
        do_write(2'd3, MODE_SHL, 8'h00);
        read_a(2'd3);
        check_eq("shl_nocarry_val", a0, 8'h80);
        check_eq("shl_nocarry_carry", c0, 1'b0);
        check_eq("shl_nocarry_zero", z0, 1'b0);

        // we=0 with INC for 5 cycles, then reserved mode and HOLD: nothing changes
        @(negedge clk_i);
        we_i    = 1'b0;
        wsel_i  = 2'd3;
        wmode_i = MODE_INC;
        repeat (5) @(posedge clk_i);
        #1;
        read_a(2'd3);
        check_eq("we0_hold_val", a0, 8'h80);
        check_eq("we0_hold_carry", c0, 1'b0);
        check_eq("we0_hold_zero", z0, 1'b0);
        do_write(2'd3, MODE_RSVD, 8'hFF);
        read_a(2'd3);
        check_eq("rsvd_val", a0, 8'h80);
        check_eq("rsvd_zero", z0, 1'b0);
        do_write(2'd1, MODE_CLR, 8'h00);
        do_write(2'd1, MODE_HOLD, 8'h00);
        read_a(2'd1);
        check_eq("clr_val", a0, 8'h00);
        check_eq("hold_keeps_zero", z0, 1'b1);

        // Bypass: same-cycle visibility on the bypass bank only
        @(negedge clk_i);
        rsel_a_i = 2'd1;
        rsel_b_i = 2'd1;
        we_i     = 1'b1;
        wsel_i   = 2'd1;
        wmode_i  = MODE_LOAD;
        wdata_i  = 8'h3C;
        #1;
        check_eq("bypass_a_same_cycle", a1, 8'h3C);
        check_eq("bypass_b_same_cycle", b1, 8'h3C);
        check_eq("nobypass_old_value", a0, 8'h00);
        @(posedge clk_i);
        #1;
        we_i = 1'b0;
        check_eq("nobypass_after_edge", a0, 8'h3C);

        // Reset asserted during a write loses the write
        @(negedge clk_i);
        rsel_a_i = 2'd2;
        we_i     = 1'b1;
        wsel_i   = 2'd2;
        wmode_i  = MODE_LOAD;
        wdata_i  = 8'h77;
        #2;
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        we_i = 1'b0;
        check_eq("reset_during_write", a0, 8'h00);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_eq("write_lost_after_reset", a0, 8'h00);
        check_eq("reset_zero_after", z0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
